// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line, frame options and receive results of uart_rx
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  RX_IN;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;
  logic                  busy;

  modport master (
    output RX_IN, PAR_EN, PAR_TYP,
    input  P_DATA, data_valid, par_err, stp_err, busy
  );

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP,
    output P_DATA, data_valid, par_err, stp_err, busy
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver: 2-flop sync, bit timing, frame FSM
// Define UART_RX_MAJORITY_VOTE_EN to decide each bit by 3-sample majority
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8
) (
  input logic      CLK,
  input logic      RST,
  uart_rx_if.slave bus
);
  localparam int M  = PRESCALE / 2;
  localparam int EW = $clog2(PRESCALE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [EW-1:0] EDGE_LAST = EW'(PRESCALE - 1);
  localparam logic [EW-1:0] EDGE_DEC  = EW'(M + 1);
  localparam logic [EW-1:0] EDGE_MID  = EW'(M);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                r_state;
  logic                  r_sync1;
  logic                  r_rx_s;
  logic [EW-1:0]         r_edge_cnt;
  logic [BW-1:0]         r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_p_data;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_par_err_int;
  logic                  r_samp_mid;
  logic                  r_data_valid;
  logic                  r_par_err;
  logic                  r_stp_err;
  logic                  r_busy;
  logic                  w_bit;
  logic                  w_wrap;
  logic                  w_decide;

  assign w_wrap   = (r_edge_cnt == EDGE_LAST);
  assign w_decide = (r_edge_cnt == EDGE_DEC);

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic r_samp_early;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_samp_early <= 1'b1;
      r_samp_mid   <= 1'b1;
    end else begin
      if (r_edge_cnt == EW'(M - 1)) r_samp_early <= r_rx_s;
      if (r_edge_cnt == EDGE_MID)   r_samp_mid   <= r_rx_s;
    end
  end

  // Third vote is the live sample at the decision edge itself
  assign w_bit = (r_samp_early & r_samp_mid) | (r_samp_early & r_rx_s) | (r_samp_mid & r_rx_s);
`else
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_samp_mid <= 1'b1;
    end else if (r_edge_cnt == EDGE_MID) begin
      r_samp_mid <= r_rx_s;
    end
  end

  assign w_bit = r_samp_mid;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= IDLE;
      r_sync1       <= 1'b1;
      r_rx_s        <= 1'b1;
      r_edge_cnt    <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_p_data      <= '0;
      r_par_en      <= 1'b0;
      r_par_typ     <= 1'b0;
      r_par_err_int <= 1'b0;
      r_data_valid  <= 1'b0;
      r_par_err     <= 1'b0;
      r_stp_err     <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_sync1      <= bus.RX_IN;
      r_rx_s       <= r_sync1;
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
      r_edge_cnt   <= w_wrap ? '0 : r_edge_cnt + 1'b1;
      case (r_state)
        IDLE: begin
          r_edge_cnt <= '0;
          r_bit_cnt  <= '0;
          if (!r_rx_s) begin
            r_state       <= START;
            r_busy        <= 1'b1;
            r_edge_cnt    <= EW'(1);
            r_par_en      <= bus.PAR_EN;
            r_par_typ     <= bus.PAR_TYP;
            r_par_err_int <= 1'b0;
          end
        end
        START: begin
          if (w_decide && w_bit) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_wrap) begin
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_decide) r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
          if (w_wrap) begin
            if (r_bit_cnt == BIT_LAST) begin
              r_bit_cnt <= '0;
              r_state   <= r_par_en ? PARITY : STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (w_decide) r_par_err_int <= (w_bit != ((^r_shift) ^ r_par_typ));
          if (w_wrap) r_state <= STOP;
        end
        STOP: begin
          // Leave mid-stop-bit so the next start edge is caught without delay
          if (w_decide) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_edge_cnt <= '0;
            r_stp_err  <= ~w_bit;
            r_par_err  <= r_par_err_int;
            if (w_bit && !r_par_err_int) begin
              r_data_valid <= 1'b1;
              r_p_data     <= r_shift;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.P_DATA     = r_p_data;
  assign bus.data_valid = r_data_valid;
  assign bus.par_err    = r_par_err;
  assign bus.stp_err    = r_stp_err;
  assign bus.busy       = r_busy;
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - table-driven frames plus glitch, majority and reset sequences for uart_rx
module tb_uart_rx;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  uart_rx_if #(.DATA_WIDTH(8)) bus ();

  uart_rx #(.DATA_WIDTH(8), .PRESCALE(8)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       pt;
    logic       pbit;
    logic       sbit;
    int         exp_dv;
    int         exp_pe;
    int         exp_se;
    logic [7:0] exp_pd;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Line offset k drives what rx_s shows at frame cycle t0+k; the strobe lands 2 cycles later
  task automatic run_frame(input logic [7:0] data, input logic pe, input logic pt,
                           input logic pbit, input logic sbit, input int glitch_k,
                           output int dv_n, output int pe_n, output int se_n,
                           output int strobe_k, output int busy_k);
    int   n;
    int   bidx;
    logic line;
    n = 1 + 8 + int'(pe);
    dv_n = 0; pe_n = 0; se_n = 0; strobe_k = -1; busy_k = -1;
    for (int k = 0; k < (n + 2) * 8 + 4; k++) begin
      @(posedge clk); #1;
      bidx = k / 8;
      if (k >= (n + 1) * 8)          line = 1'b1;
      else if (bidx == 0)            line = 1'b0;
      else if (bidx <= 8)            line = data[bidx-1];
      else if (pe && bidx == 9)      line = pbit;
      else                           line = sbit;
      if (k == glitch_k) line = ~line;
      bus.RX_IN = line;
      if (k == 0) begin bus.PAR_EN = pe;  bus.PAR_TYP = pt;  end
      if (k == 4) begin bus.PAR_EN = ~pe; bus.PAR_TYP = ~pt; end
      @(negedge clk);
      if (bus.data_valid) dv_n++;
      if (bus.par_err)    pe_n++;
      if (bus.stp_err)    se_n++;
      if ((bus.data_valid || bus.par_err || bus.stp_err) && strobe_k < 0) strobe_k = k;
      if (bus.busy && busy_k < 0) busy_k = k;
    end
  endtask

  task automatic idle(input int cycles, output int strobes, output int busy_n);
    strobes = 0; busy_n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      bus.RX_IN = 1'b1;
      @(negedge clk);
      if (bus.data_valid || bus.par_err || bus.stp_err) strobes++;
      if (bus.busy) busy_n++;
    end
  endtask

  initial begin
    int dv_n, pe_n, se_n, strobe_k, busy_k, strobes, busy_n, exp_k;
    logic [7:0] exp_maj;
    n_cmp = 0;
    n_err = 0;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 0, 8'hA5};
    vecs[1] = '{8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1, 0, 8'hA5};
    vecs[2] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1, 8'hA5};
    vecs[3] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 0, 8'h3C};
    vecs[4] = '{8'h96, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0, 0, 8'h96};
    vecs[5] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 1, 0, 0, 8'h07};
    vecs[6] = '{8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1, 1, 8'h07};
    vecs[7] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 0, 8'h00};

    bus.RX_IN = 1'b1; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset P_DATA",     int'(bus.P_DATA), 0);
    chk("reset data_valid", int'(bus.data_valid), 0);
    chk("reset par_err",    int'(bus.par_err), 0);
    chk("reset stp_err",    int'(bus.stp_err), 0);
    chk("reset busy",       int'(bus.busy), 0);
    idle(4, strobes, busy_n);

    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i].data, vecs[i].pe, vecs[i].pt, vecs[i].pbit, vecs[i].sbit, -1,
                dv_n, pe_n, se_n, strobe_k, busy_k);
      exp_k = vecs[i].pe ? 88 : 80;
      chk($sformatf("vec%0d data_valid", i), dv_n, vecs[i].exp_dv);
      chk($sformatf("vec%0d par_err", i),    pe_n, vecs[i].exp_pe);
      chk($sformatf("vec%0d stp_err", i),    se_n, vecs[i].exp_se);
      chk($sformatf("vec%0d strobe cycle", i), strobe_k, exp_k);
      chk($sformatf("vec%0d busy rise", i),  busy_k, 3);
      chk($sformatf("vec%0d P_DATA", i),     int'(bus.P_DATA), int'(vecs[i].exp_pd));
      idle(6, strobes, busy_n);
      chk($sformatf("vec%0d idle after", i), busy_n, 0);
    end

    // Two-cycle low pulse: false start, busy for t0+1..t0+5 only
    strobes = 0; busy_n = 0;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk); #1;
      bus.RX_IN = (k < 2) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (bus.data_valid || bus.par_err || bus.stp_err) strobes++;
      if (bus.busy) busy_n++;
    end
    chk("glitch strobes", strobes, 0);
    chk("glitch busy cycles", busy_n, 5);
    chk("glitch P_DATA", int'(bus.P_DATA), 8'h00);

`ifdef UART_RX_MAJORITY_VOTE_EN
    exp_maj = 8'h01;
`else
    exp_maj = 8'h00;
`endif
    run_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 12, dv_n, pe_n, se_n, strobe_k, busy_k);
    chk("midbit flip data_valid", dv_n, 1);
    chk("midbit flip P_DATA", int'(bus.P_DATA), int'(exp_maj));
    idle(6, strobes, busy_n);

    // Abort mid-DATA of an 0xFF frame
    for (int k = 0; k < 31; k++) begin
      @(posedge clk); #1;
      bus.RX_IN = (k < 8) ? 1'b0 : 1'b1;
      if (k == 30) rst = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midframe rst P_DATA", int'(bus.P_DATA), 0);
    chk("midframe rst busy",   int'(bus.busy), 0);
    chk("midframe rst data_valid", int'(bus.data_valid), 0);
    idle(80, strobes, busy_n);
    chk("after rst strobes", strobes, 0);
    chk("after rst busy", busy_n, 0);
    run_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, -1, dv_n, pe_n, se_n, strobe_k, busy_k);
    chk("post-rst data_valid", dv_n, 1);
    chk("post-rst strobe cycle", strobe_k, 80);
    chk("post-rst P_DATA", int'(bus.P_DATA), 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
